pid_mc_core: RTL and testbench
==============================

# pid_mc_core

Time-multiplexed multi-channel fixed-point PID controller for normalized V–I control loops. Serves NCH independent channels with one shared signed multiplier. Each channel keeps its own gains, integral accumulator and previous error. It adds conditional-integration anti-windup and per-channel state clear. It sits between the V–I sample front-end (valid/ready stream) and the PWM mapping stage.

## Interface
- W, 16, sample/gain/output width (Q1.(W-1) signed)
- FRAC, 15, fractional bits removed after each product
- IACC_W, 32, integral accumulator width
- NCH, 4, channel count (≥2); CH_W = $clog2(NCH) is derived, not overridable
- I_ACC_MAX, 32'sh0FFFFFFF, integral upper clamp
- I_ACC_MIN, -32'sh10000000, integral lower clamp
- DF_SHIFT, 2, derivative filter shift (used only with the macro)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  sample offered
- in_ready  out  1  core idle, sample accepted when in_valid&&in_ready
- in_ch  in  CH_W  channel of sample
- v_in  in  W  measured V[n]
- v_ref  in  W  reference Vref[n]
- cfg_we  in  1  gain write strobe
- cfg_ch  in  CH_W  gain target channel
- cfg_sel  in  2  0=kp, 1=ki, 2=kd, 3=ignored
- cfg_data  in  W  gain value
- ch_clr  in  1  clear channel state strobe
- ch_clr_id  in  CH_W  channel to clear
- out_valid  out  1  one-cycle result strobe
- out_ch  out  CH_W  channel of result
- u_out  out  W  saturated output
- u_sat  out  1  sum was clipped this result

## Operation
- FSM states: IDLE → MP → MI → MD → SUM → IDLE. in_ready = 1 only in IDLE.
- Accept in IDLE:
  - e = v_ref − v_in in W+1 bits, sign-extended.
  - Latch channel id, kp/ki/kd, i_acc[ch] and e_prev[ch] into working registers.
- in_ch ≥ NCH: the sample is accepted but dropped. No out_valid. FSM stays IDLE.
- MP: p = (e*kp) >>> FRAC.
- MI: i = (i_acc*ki) >>> FRAC. Uses the pre-update accumulator.
- MD: d = ((e − e_prev)*kd) >>> FRAC. The difference is W+2 bits.
- All shifts are arithmetic (floor). Products are full width: 2W+1 and IACC_W+W bits.
- SUM:
  - s = p + i + d in IACC_W+W+2 bits.
  - Saturate s to [−2^(W−1), 2^(W−1)−1].
  - Register u_out, out_ch and u_sat. Pulse out_valid.
  - Write back e_prev[ch] = e.
- Integral update in SUM:
  - i_next = i_acc + e, clamped to [I_ACC_MIN, I_ACC_MAX].
  - Anti-windup: skip the update (i_acc unchanged) when u_sat=1 and sign(e) equals sign(s).
- Gain writes:
  - Apply at any time, one cycle after cfg_we.
  - The running computation uses the latched copy, so a write takes effect from the next accepted sample.
- ch_clr:
  - Zeroes i_acc[ch_clr_id] and e_prev[ch_clr_id] (and the filter state).
  - If it coincides with SUM writeback to the same channel, the clear wins.
  - Gains are not cleared.

## Timing
- Reset values (asserted asynchronously):
  - FSM = IDLE; in_ready = 0 (becomes 1 on the first clk after rst_n rises).
  - out_valid = 0, u_out = 0, out_ch = 0, u_sat = 0.
  - All i_acc, e_prev and gains = 0.
- Accept on edge k. out_valid is high for exactly the cycle after edge k+4 (latency 4).
- in_ready is high in that same cycle, so back-to-back throughput is 1 sample per 5 cycles.
- in_valid held while in_ready=0 is not consumed. v_in, v_ref and in_ch only need to be stable at the accepting edge.
- Reset mid-computation aborts the computation. No out_valid and no state writeback.

## Configuration
- PID_MC_DFILT_EN defined:
  - Each channel holds df[ch] (W+2 bits).
  - In MD, df ← df + ((e − e_prev − df) >>> DF_SHIFT). The multiplier uses df instead of the raw difference.
  - df is written back in SUM and cleared by ch_clr and reset.
- PID_MC_DFILT_EN undefined: raw difference is used, no df storage. Latency is identical either way.

## Test plan
- Proportional only: ch0 kp=0x4000, ki=kd=0, v_ref=0x2000, v_in=0. Expect u_out=0x1000, out_ch=0, out_valid exactly 4 cycles after accept, u_sat=0.
- Integral accumulation: ch1 ki=0x4000, kp=kd=0, four samples with e=0x1000. Expect u_out = 0, 0x0800, 0x1000, 0x1800 (pre-update accumulator).
- Saturation and anti-windup: ch2 kp=0x7FFF, ki=0x0100, v_ref=0x7FFF, v_in=0x8000. Expect u_out=0x7FFF, u_sat=1, i_acc[2] frozen at 0 across 10 samples.
- Channel isolation and clear:
  - Interleave ch0 and ch3 samples and check that the accumulators stay independent.
  - ch_clr ch3 coincident with its SUM. Expect the next ch3 I-term = 0 and ch0 unaffected.
- Handshake and bad channel:
  - Hold in_valid=1 continuously. Expect one accept per 5 cycles.
  - in_ch=NCH (NCH=5 build). Expect no out_valid.
  - rst_n low during MI. Expect outputs zeroed immediately and no writeback.
- Derivative (both macro settings): kd=0x4000, e steps 0 → 0x2000.
  - Raw build: d=0x1000.
  - Filtered build (DF_SHIFT=2): d=0x0400.

Source files
------------

// File: rtl/pid_mc_core.sv
// pid_mc_core: time-multiplexed NCH-channel fixed-point PID sharing one signed multiplier.
// Define PID_MC_DFILT_EN to add a per-channel first-order derivative filter (shift DF_SHIFT).

module pid_mc_chan #(
   parameter int W      = 16,
   parameter int IACC_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [1:0]        cfg_sel,
   input  logic [W-1:0]      cfg_data,
   input  logic              clr,
   input  logic              wb,
   input  logic              i_we,
   input  logic [IACC_W-1:0] i_nxt,
   input  logic [W:0]        e_nxt,
`ifdef PID_MC_DFILT_EN
   input  logic [W+1:0]      df_nxt,
   output logic [W+1:0]      df,
`endif
   output logic [W-1:0]      kp,
   output logic [W-1:0]      ki,
   output logic [W-1:0]      kd,
   output logic [IACC_W-1:0] i_acc,
   output logic [W:0]        e_prev
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         kp <= '0;
         ki <= '0;
         kd <= '0;
      end else if (cfg_we) begin
         case (cfg_sel)
            2'd0:    kp <= cfg_data;
            2'd1:    ki <= cfg_data;
            2'd2:    kd <= cfg_data;
            default: ;
         endcase
      end
   end

   // Clear takes priority over a writeback landing in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_acc  <= '0;
         e_prev <= '0;
      end else if (clr) begin
         i_acc  <= '0;
         e_prev <= '0;
      end else if (wb) begin
         e_prev <= e_nxt;
         if (i_we) i_acc <= i_nxt;
      end
   end

`ifdef PID_MC_DFILT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   df <= '0;
      else if (clr) df <= '0;
      else if (wb)  df <= df_nxt;
   end
`endif

endmodule

module pid_mc_core #(
   parameter int                        W         = 16,
   parameter int                        FRAC      = 15,
   parameter int                        IACC_W    = 32,
   parameter int                        NCH       = 4,
   parameter logic signed [IACC_W-1:0]  I_ACC_MAX = 32'sh0FFFFFFF,
   parameter logic signed [IACC_W-1:0]  I_ACC_MIN = -32'sh10000000,
   parameter int                        DF_SHIFT  = 2,
   localparam int                       CH_W      = $clog2(NCH)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH_W-1:0] in_ch,
   input  logic [W-1:0]    v_in,
   input  logic [W-1:0]    v_ref,
   input  logic            cfg_we,
   input  logic [CH_W-1:0] cfg_ch,
   input  logic [1:0]      cfg_sel,
   input  logic [W-1:0]    cfg_data,
   input  logic            ch_clr,
   input  logic [CH_W-1:0] ch_clr_id,
   output logic            out_valid,
   output logic [CH_W-1:0] out_ch,
   output logic [W-1:0]    u_out,
   output logic            u_sat
);

   localparam int MA_W = (IACC_W > W + 2) ? IACC_W : W + 2;
   localparam int PR_W = MA_W + W;
   localparam int S_W  = PR_W + 2;
   localparam int DW   = W + 2;

   localparam logic signed [S_W-1:0]    S_MAX = {{(S_W-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [S_W-1:0]    S_MIN = {{(S_W-W+1){1'b1}}, {(W-1){1'b0}}};
   localparam logic signed [IACC_W:0]   I_HI  = (IACC_W+1)'(I_ACC_MAX);
   localparam logic signed [IACC_W:0]   I_LO  = (IACC_W+1)'(I_ACC_MIN);

   typedef enum logic [2:0] {IDLE, MP, MI, MD, SUM} state_t;

   state_t state, state_nxt;

   logic                         ch_ok, acc, wb;
   logic signed [W:0]            e_in;
   logic [CH_W-1:0]              ch_q;
   logic signed [W:0]            e_q, ep_q;
   logic signed [W-1:0]          kp_q, ki_q, kd_q;
   logic signed [IACC_W-1:0]     ia_q;
   logic signed [PR_W-1:0]       p_q, i_q, d_q;
   logic signed [DW-1:0]         diff, dsel;
   logic signed [MA_W-1:0]       mul_a;
   logic signed [W-1:0]          mul_b;
   logic signed [PR_W-1:0]       mul_p, mul_sh;
   logic signed [S_W-1:0]        s_sum;
   logic                         s_hi, s_lo, sat, aw_hold;
   logic [W-1:0]                 u_n;
   logic signed [IACC_W:0]       i_sum;
   logic [IACC_W-1:0]            i_nxt;

   logic [NCH-1:0][W-1:0]        kp_a, ki_a, kd_a;
   logic [NCH-1:0][IACC_W-1:0]   ia_a;
   logic [NCH-1:0][W:0]          ep_a;

   // Non-power-of-two channel counts leave ids that must be swallowed.
   generate
      if (NCH == (1 << CH_W)) begin : g_ch_full
         assign ch_ok = 1'b1;
      end else begin : g_ch_part
         assign ch_ok = (in_ch < CH_W'(NCH));
      end
   endgenerate

   assign acc  = in_valid && in_ready;
   assign e_in = $signed({v_ref[W-1], v_ref}) - $signed({v_in[W-1], v_in});
   assign wb   = (state == SUM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (acc && ch_ok) state_nxt = MP;
         MP:      state_nxt = MI;
         MI:      state_nxt = MD;
         MD:      state_nxt = SUM;
         SUM:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Registered so ready stays low through the first clock after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) in_ready <= 1'b0;
      else        in_ready <= (state_nxt == IDLE);
   end

`ifdef PID_MC_DFILT_EN
   logic [NCH-1:0][DW-1:0] df_a;
   logic signed [DW-1:0]   df_q, df_new;
   logic signed [DW:0]     df_err;

   assign df_err = (DW+1)'(diff) - (DW+1)'(df_q);
   assign df_new = df_q + DW'(df_err >>> DF_SHIFT);
   assign dsel   = df_new;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              df_q <= '0;
      else if (acc && ch_ok)   df_q <= df_a[in_ch];
   end
`else
   assign dsel = diff;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q <= '0;
         e_q  <= '0;
         ep_q <= '0;
         kp_q <= '0;
         ki_q <= '0;
         kd_q <= '0;
         ia_q <= '0;
      end else if (acc && ch_ok) begin
         ch_q <= in_ch;
         e_q  <= e_in;
         ep_q <= ep_a[in_ch];
         kp_q <= kp_a[in_ch];
         ki_q <= ki_a[in_ch];
         kd_q <= kd_a[in_ch];
         ia_q <= ia_a[in_ch];
      end
   end

   assign diff = DW'(e_q) - DW'(ep_q);

   always_comb begin
      mul_a = '0;
      mul_b = '0;
      case (state)
         MP: begin mul_a = MA_W'(e_q);  mul_b = kp_q; end
         MI: begin mul_a = MA_W'(ia_q); mul_b = ki_q; end
         MD: begin mul_a = MA_W'(dsel); mul_b = kd_q; end
         default: ;
      endcase
   end

   assign mul_p  = PR_W'(mul_a) * PR_W'(mul_b);
   assign mul_sh = mul_p >>> FRAC;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p_q <= '0;
         i_q <= '0;
         d_q <= '0;
      end else begin
         if (state == MP) p_q <= mul_sh;
         if (state == MI) i_q <= mul_sh;
         if (state == MD) d_q <= mul_sh;
      end
   end

   assign s_sum = S_W'(p_q) + S_W'(i_q) + S_W'(d_q);
   assign s_hi  = (s_sum > S_MAX);
   assign s_lo  = (s_sum < S_MIN);
   assign sat   = s_hi || s_lo;
   assign u_n   = s_hi ? {1'b0, {(W-1){1'b1}}} :
                  s_lo ? {1'b1, {(W-1){1'b0}}} : s_sum[W-1:0];

   // Conditional integration: hold the accumulator while pushing further into saturation.
   assign aw_hold = sat && (e_q[W] == s_sum[S_W-1]);
   assign i_sum   = (IACC_W+1)'(ia_q) + (IACC_W+1)'(e_q);
   assign i_nxt   = (i_sum > I_HI) ? I_ACC_MAX :
                    (i_sum < I_LO) ? I_ACC_MIN : i_sum[IACC_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         u_out     <= '0;
         out_ch    <= '0;
         u_sat     <= 1'b0;
      end else begin
         out_valid <= wb;
         if (wb) begin
            u_out  <= u_n;
            out_ch <= ch_q;
            u_sat  <= sat;
         end
      end
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      pid_mc_chan #(.W(W), .IACC_W(IACC_W)) u_ch (
         .clk      (clk),
         .rst_n    (rst_n),
         .cfg_we   (cfg_we && (cfg_ch == CH_W'(c))),
         .cfg_sel  (cfg_sel),
         .cfg_data (cfg_data),
         .clr      (ch_clr && (ch_clr_id == CH_W'(c))),
         .wb       (wb && (ch_q == CH_W'(c))),
         .i_we     (!aw_hold),
         .i_nxt    (i_nxt),
         .e_nxt    (e_q),
`ifdef PID_MC_DFILT_EN
         .df_nxt   (df_new),
         .df       (df_a[c]),
`endif
         .kp       (kp_a[c]),
         .ki       (ki_a[c]),
         .kd       (kd_a[c]),
         .i_acc    (ia_a[c]),
         .e_prev   (ep_a[c])
      );
   end

endmodule

// File: tb/tb_pid_mc_core.sv
// Scoreboard bench for pid_mc_core (NCH=5 build): behavioural model predicts each result at accept time.
module tb_pid_mc_core;
   localparam int W    = 16;
   localparam int NCH  = 5;
   localparam int CH_W = 3;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            in_valid = 1'b0, in_ready;
   logic [CH_W-1:0] in_ch = '0;
   logic [W-1:0]    v_in = '0, v_ref = '0;
   logic            cfg_we = 1'b0;
   logic [CH_W-1:0] cfg_ch = '0;
   logic [1:0]      cfg_sel = '0;
   logic [W-1:0]    cfg_data = '0;
   logic            ch_clr = 1'b0;
   logic [CH_W-1:0] ch_clr_id = '0;
   logic            out_valid, u_sat;
   logic [CH_W-1:0] out_ch;
   logic [W-1:0]    u_out;

   pid_mc_core #(.NCH(NCH)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch),
      .v_in(v_in), .v_ref(v_ref), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_sel(cfg_sel),
      .cfg_data(cfg_data), .ch_clr(ch_clr), .ch_clr_id(ch_clr_id), .out_valid(out_valid),
      .out_ch(out_ch), .u_out(u_out), .u_sat(u_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CH_W-1:0] ch;
      logic [W-1:0]    u;
      logic            sat;
      longint          cyc;
   } exp_t;

   exp_t   sbq[$];
   int     errs = 0, checks = 0, n_out = 0;
   longint cyc = 0, acc_cyc = 0;
   logic [W-1:0] last_u = '0;
   logic         last_sat = 1'b0;

   int     m_kp[NCH], m_ki[NCH], m_kd[NCH];
   longint m_ia[NCH], m_ep[NCH], m_df[NCH];

   logic [W-1:0] exp_i[4] = '{16'h0000, 16'h0800, 16'h1000, 16'h1800};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h want %0h", tag, act, exp);
      end
   endtask

   task automatic model_clear(input int ch);
      m_ia[ch] = 0; m_ep[ch] = 0; m_df[ch] = 0;
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_kp[c] = 0; m_ki[c] = 0; m_kd[c] = 0;
         model_clear(c);
      end
   endtask

   task automatic predict(input int ch, input longint e);
      longint p, i, dd, d, s, u;
      bit sat;
      p  = (e * m_kp[ch]) >>> 15;
      i  = (m_ia[ch] * m_ki[ch]) >>> 15;
      dd = e - m_ep[ch];
`ifdef PID_MC_DFILT_EN
      m_df[ch] = m_df[ch] + ((dd - m_df[ch]) >>> 2);
      dd = m_df[ch];
`endif
      d   = (dd * m_kd[ch]) >>> 15;
      s   = p + i + d;
      sat = (s > 32767) || (s < -32768);
      u   = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
      if (!(sat && ((e < 0) == (s < 0)))) begin
         m_ia[ch] = m_ia[ch] + e;
         if (m_ia[ch] > 64'sh0FFFFFFF)  m_ia[ch] = 64'sh0FFFFFFF;
         if (m_ia[ch] < -64'sh10000000) m_ia[ch] = -64'sh10000000;
      end
      m_ep[ch] = e;
      sbq.push_back('{ch: CH_W'(ch), u: W'(u), sat: sat, cyc: cyc + 5});
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (rst_n && out_valid) begin
         n_out++;
         if (sbq.size() == 0) chk("out_unexpected", out_valid, 1'b0);
         else begin
            x = sbq.pop_front();
            chk("u_out", u_out, x.u);
            chk("u_sat", u_sat, x.sat);
            chk("out_ch", out_ch, x.ch);
            chk("latency", cyc, x.cyc);
            last_u   = u_out;
            last_sat = u_sat;
         end
      end
   end

   task automatic cfg(input int ch, input int sel, input logic [W-1:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_ch = CH_W'(ch); cfg_sel = 2'(sel); cfg_data = d;
      @(negedge clk);
      cfg_we = 1'b0;
      case (sel)
         0: m_kp[ch] = int'($signed(d));
         1: m_ki[ch] = int'($signed(d));
         2: m_kd[ch] = int'($signed(d));
         default: ;
      endcase
   endtask

   task automatic send(input int ch, input logic [W-1:0] vr, input logic [W-1:0] vi, input bit keep);
      int n = 0;
      @(negedge clk);
      in_ch = CH_W'(ch); v_ref = vr; v_in = vi; in_valid = 1'b1;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (n >= 40) begin
         chk("accept_timeout", in_ready, 1'b1);
         in_valid = 1'b0;
      end else begin
         if (ch < NCH) predict(ch, longint'($signed(vr)) - longint'($signed(vi)));
         acc_cyc = cyc + 1;
         @(posedge clk);
         #1;
         if (!keep) in_valid = 1'b0;
      end
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("drain", sbq.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      longint a_prev;
      int nb;
      model_reset();
      #23;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_u_out", u_out, 16'h0);
      chk("rst_out_ch", out_ch, 3'h0);
      chk("rst_u_sat", u_sat, 1'b0);
      chk("rst_in_ready", in_ready, 1'b0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("rdy_before_clk", in_ready, 1'b0);
      @(negedge clk); chk("rdy_after_clk", in_ready, 1'b1);

      // proportional only
      cfg(0, 0, 16'h4000);
      send(0, 16'h2000, 16'h0000, 0); drain();
      chk("p_only", last_u, 16'h1000);
      chk("p_only_sat", last_sat, 1'b0);

      // integral uses pre-update accumulator
      cfg(1, 1, 16'h4000);
      for (int k = 0; k < 4; k++) begin
         send(1, 16'h1000, 16'h0000, 0); drain();
         chk("i_accum", last_u, exp_i[k]);
      end

      // saturation with anti-windup
      cfg(2, 0, 16'h7FFF); cfg(2, 1, 16'h0100);
      for (int k = 0; k < 10; k++) begin
         send(2, 16'h7FFF, 16'h8000, 0); drain();
      end
      chk("sat_u", last_u, 16'h7FFF);
      chk("sat_flag", last_sat, 1'b1);
      cfg(2, 0, 16'h0000);
      send(2, 16'h0000, 16'h0000, 0); drain();
      chk("aw_frozen", last_u, 16'h0000);

      // interleaved channels, then clear coincident with SUM
      cfg(0, 0, 16'h0000); cfg(0, 1, 16'h4000); cfg(3, 1, 16'h2000);
      for (int k = 0; k < 6; k++) begin
         send(0, 16'($urandom_range(0, 16'h0FFF)), 16'h0000, 0);
         send(3, 16'h0000, 16'($urandom_range(0, 16'h0FFF)), 0);
      end
      drain();
      send(3, 16'h0100, 16'h0000, 0);
      repeat (4) @(negedge clk);
      ch_clr = 1'b1; ch_clr_id = 3'd3; model_clear(3);
      @(negedge clk); ch_clr = 1'b0;
      drain();
      send(3, 16'h0000, 16'h0000, 0); drain();
      chk("clr_i_term", last_u, 16'h0000);
      send(0, 16'h0400, 16'h0000, 0); drain();

      // gain write mid-computation affects only the next sample
      cfg(0, 0, 16'h4000);
      send(0, 16'h2000, 16'h0000, 0);
      cfg(0, 0, 16'h7FFF);
      drain();
      send(0, 16'h2000, 16'h0000, 0); drain();

      // derivative step
      cfg(4, 2, 16'h4000);
      send(4, 16'h0000, 16'h0000, 0);
      send(4, 16'h2000, 16'h0000, 0); drain();
`ifdef PID_MC_DFILT_EN
      chk("d_step", last_u, 16'h0400);
`else
      chk("d_step", last_u, 16'h1000);
`endif

      // held in_valid: one accept per 5 cycles
      a_prev = 0;
      for (int k = 0; k < 4; k++) begin
         send(4, 16'($urandom_range(0, 16'h3FFF)), 16'($urandom_range(0, 16'h3FFF)), 1);
         if (k > 0) chk("throughput", acc_cyc - a_prev, 5);
         a_prev = acc_cyc;
      end
      in_valid = 1'b0;
      drain();

      // out-of-range channel is swallowed
      nb = n_out;
      send(5, 16'h1234, 16'h0000, 0);
      @(negedge clk); chk("bad_ch_ready", in_ready, 1'b1);
      repeat (8) @(negedge clk);
      chk("bad_ch_no_out", n_out, nb);

      // random mix across all channels
      for (int k = 0; k < 15; k++) begin
         if (k % 5 == 0) cfg($urandom_range(0, NCH-1), $urandom_range(0, 3), 16'($urandom));
         send($urandom_range(0, NCH-1), 16'($urandom), 16'($urandom), 0);
      end
      drain();

      // reset during MI
      send(1, 16'h0800, 16'h0000, 0);
      @(posedge clk); #2;
      rst_n = 1'b0; #1;
      chk("mid_rst_out_valid", out_valid, 1'b0);
      chk("mid_rst_u_out", u_out, 16'h0);
      chk("mid_rst_out_ch", out_ch, 3'h0);
      chk("mid_rst_u_sat", u_sat, 1'b0);
      chk("mid_rst_in_ready", in_ready, 1'b0);
      sbq.delete();
      model_reset();
      nb = n_out;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("mid_rst_no_out", n_out, nb);
      cfg(1, 1, 16'h4000);
      send(1, 16'h1000, 16'h0000, 0); drain();
      chk("mid_rst_no_wb", last_u, 16'h0000);

      chk("sb_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
